// File: rtl/asic_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// asic_gpio_ctrl
//
// Core-side GPIO controller for one padring side. Drives dout/oen/ie into the
// padring, synchronizes din coming back, detects edges on it and raises a
// level interrupt. Software access is a single-outstanding valid/ready
// register port.
//
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   req_*         register request (valid/ready, write, 3-bit index, wdata)
//   rsp_*         register response (valid/ready, rdata; 0 for writes)
//   pad_din       asynchronous data from pads
//   pad_dout      data to pads (DOUT register)
//   pad_oen       output enable, active low (OEN register)
//   pad_ie        input enable (IE register)
//   irq           registered level interrupt, |(IRQ_STATUS & IRQ_EN)
//
// Register map: 0 DOUT, 1 OEN, 2 IE, 3 DIN (ro), 4 IRQ_EN, 5 IRQ_EDGE
// (1=rising), 6 IRQ_STATUS (w1c), 7 reserved (reads 0, writes ignored).
// ---------------------------------------------------------------------------
module asic_gpio_ctrl #(
  parameter int unsigned NGPIO = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [NGPIO-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NGPIO-1:0] rsp_rdata,
  input  logic [NGPIO-1:0] pad_din,
  output logic [NGPIO-1:0] pad_dout,
  output logic [NGPIO-1:0] pad_oen,
  output logic [NGPIO-1:0] pad_ie,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DOUT       = 3'd0,
    REG_OEN        = 3'd1,
    REG_IE         = 3'd2,
    REG_DIN        = 3'd3,
    REG_IRQ_EN     = 3'd4,
    REG_IRQ_EDGE   = 3'd5,
    REG_IRQ_STATUS = 3'd6,
    REG_RSVD       = 3'd7
  } reg_idx_e;

  // Software-visible registers
  logic [NGPIO-1:0] dout_q,       dout_d;
  logic [NGPIO-1:0] oen_q,        oen_d;
  logic [NGPIO-1:0] ie_q,         ie_d;
  logic [NGPIO-1:0] irq_en_q,     irq_en_d;
  logic [NGPIO-1:0] irq_edge_q,   irq_edge_d;
  logic [NGPIO-1:0] irq_status_q, irq_status_d;

  // Input synchronizer / history and the matching IE pipeline
  logic [NGPIO-1:0] s1_q, s2_q, s3_q;
  logic [NGPIO-1:0] e1_q, e2_q, e3_q;

  // Response channel and interrupt
  logic             rsp_valid_q, rsp_valid_d;
  logic [NGPIO-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             irq_q,       irq_d;

  reg_idx_e         addr;
  logic             accept;
  logic             wr;
  logic [NGPIO-1:0] rd_mux;
  logic [NGPIO-1:0] edge_event;
  logic [NGPIO-1:0] status_clr;

  assign addr      = reg_idx_e'(req_addr);
  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign wr        = accept & req_write;

  assign pad_dout  = dout_q;
  assign pad_oen   = oen_q;
  assign pad_ie    = ie_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq       = irq_q;

  // Read mux, sampled on the accept edge; DIN returns the synchronized s2.
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DOUT:       rd_mux = dout_q;
      REG_OEN:        rd_mux = oen_q;
      REG_IE:         rd_mux = ie_q;
      REG_DIN:        rd_mux = s2_q;
      REG_IRQ_EN:     rd_mux = irq_en_q;
      REG_IRQ_EDGE:   rd_mux = irq_edge_q;
      REG_IRQ_STATUS: rd_mux = irq_status_q;
      default:        rd_mux = '0;
    endcase
  end

  // An edge only counts once IE has been on for both compared samples, so
  // the masked-0 -> live-1 step seen when IE is first enabled is ignored.
  // Direction matches when the new level s2 equals the IRQ_EDGE bit.
  always_comb begin
    edge_event = e2_q & e3_q & (s2_q ^ s3_q) & ~(s2_q ^ irq_edge_q);
  end

  // Register next-state: writes land on the accept edge; status set beats
  // a same-cycle w1c clear because the event is OR-ed in after clearing.
  always_comb begin
    dout_d     = dout_q;
    oen_d      = oen_q;
    ie_d       = ie_q;
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    status_clr = '0;
    if (wr) begin
      case (addr)
        REG_DOUT:       dout_d     = req_wdata;
        REG_OEN:        oen_d      = req_wdata;
        REG_IE:         ie_d       = req_wdata;
        REG_IRQ_EN:     irq_en_d   = req_wdata;
        REG_IRQ_EDGE:   irq_edge_d = req_wdata;
        REG_IRQ_STATUS: status_clr = req_wdata;
        default:        ;
      endcase
    end
    irq_status_d = (irq_status_q & ~status_clr) | edge_event;
  end

  // Response channel: a new accept overwrites, otherwise hold until taken.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = req_write ? '0 : rd_mux;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    irq_d = |(irq_status_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      oen_q        <= '1;
      ie_q         <= '0;
      irq_en_q     <= '0;
      irq_edge_q   <= '0;
      irq_status_q <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      e3_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      oen_q        <= oen_d;
      ie_q         <= ie_d;
      irq_en_q     <= irq_en_d;
      irq_edge_q   <= irq_edge_d;
      irq_status_q <= irq_status_d;
      s1_q         <= pad_din & ie_q;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      e1_q         <= ie_q;
      e2_q         <= e1_q;
      e3_q         <= e2_q;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_asic_gpio_ctrl.sv
module tb_asic_gpio_ctrl;

  localparam int unsigned N = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [2:0]   req_addr;
  logic [N-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_rdata;
  logic [N-1:0] pad_din;
  logic [N-1:0] pad_dout;
  logic [N-1:0] pad_oen;
  logic [N-1:0] pad_ie;
  logic         irq;

  always #5 clk = ~clk;

  asic_gpio_ctrl #(.NGPIO(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .pad_din   (pad_din),
    .pad_dout  (pad_dout),
    .pad_oen   (pad_oen),
    .pad_ie    (pad_ie),
    .irq       (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a register file indexed by address, plus histories of
  // the masked pad value and IE seen at each clock edge (index 0 = newest).
  logic [N-1:0] r [8];
  logic [N-1:0] m_stat;
  logic         m_irq;
  logic         m_rv;
  logic [N-1:0] m_rdata;
  logic [N-1:0] mq [$];
  logic [N-1:0] iq [$];

  typedef struct {
    logic         wr;
    logic [2:0]   addr;
    logic [N-1:0] wdata;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) r[i] = '0;
    r[1]    = '1;
    m_stat  = '0;
    m_irq   = 1'b0;
    m_rv    = 1'b0;
    m_rdata = '0;
    mq.delete();
    iq.delete();
    repeat (3) begin
      mq.push_back('0);
      iq.push_back('0);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic         acc;
    logic [N-1:0] ev;
    logic [N-1:0] clr;
    logic [N-1:0] rd;
    logic         nirq;
    if (rst) begin
      model_reset();
      return;
    end
    acc = req_valid && (!m_rv || rsp_ready);
    for (int i = 0; i < N; i++)
      ev[i] = iq[1][i] && iq[2][i] && (mq[1][i] != mq[2][i]) && (mq[1][i] == r[5][i]);
    clr  = (acc && req_write && req_addr == 3'd6) ? req_wdata : '0;
    nirq = |(m_stat & r[4]);
    case (req_addr)
      3'd3:    rd = mq[1];
      3'd6:    rd = m_stat;
      3'd7:    rd = '0;
      default: rd = r[req_addr];
    endcase
    mq.push_front(pad_din & r[2]);
    void'(mq.pop_back());
    iq.push_front(r[2]);
    void'(iq.pop_back());
    m_stat = (m_stat & ~clr) | ev;
    if (acc && req_write && (req_addr <= 3'd2 || req_addr == 3'd4 || req_addr == 3'd5))
      r[req_addr] = req_wdata;
    if (acc) begin
      m_rv    = 1'b1;
      m_rdata = req_write ? '0 : rd;
    end else if (rsp_ready) begin
      m_rv = 1'b0;
    end
    m_irq = nirq;
  endtask

  // One clock: check the combinational ready, step the model, then sample
  // every output 1 time unit after the rising edge.
  task automatic tick();
    #1;
    chk("req_ready", 32'(req_ready), 32'(!m_rv || rsp_ready));
    model_step();
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    chk("pad_dout",  32'(pad_dout),  32'(r[0]));
    chk("pad_oen",   32'(pad_oen),   32'(r[1]));
    chk("pad_ie",    32'(pad_ie),    32'(r[2]));
    chk("irq",       32'(irq),       32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_req(input logic w, input logic [2:0] a, input logic [N-1:0] d,
                        output logic [N-1:0] rdata);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    rdata     = rsp_rdata;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
  endtask

  logic [N-1:0] rd;
  logic [31:0]  rnd;

  initial begin
    vt[0]  = '{1'b0, 3'd1, 9'h000, 9'h1FF};
    vt[1]  = '{1'b0, 3'd0, 9'h000, 9'h000};
    vt[2]  = '{1'b0, 3'd2, 9'h000, 9'h000};
    vt[3]  = '{1'b1, 3'd0, 9'h0A5, 9'h000};
    vt[4]  = '{1'b1, 3'd1, 9'h05A, 9'h000};
    vt[5]  = '{1'b0, 3'd0, 9'h000, 9'h0A5};
    vt[6]  = '{1'b0, 3'd1, 9'h000, 9'h05A};
    vt[7]  = '{1'b1, 3'd7, 9'h1FF, 9'h000};
    vt[8]  = '{1'b0, 3'd7, 9'h000, 9'h000};
    vt[9]  = '{1'b1, 3'd4, 9'h155, 9'h000};
    vt[10] = '{1'b0, 3'd4, 9'h000, 9'h155};
    vt[11] = '{1'b1, 3'd5, 9'h0F0, 9'h000};
    vt[12] = '{1'b0, 3'd5, 9'h000, 9'h0F0};
    vt[13] = '{1'b0, 3'd6, 9'h000, 9'h000};

    model_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    pad_din   = '0;
    idle(2);
    rst = 1'b0;
    chk("reset_oen", 32'(pad_oen), 32'h1FF);
    chk("reset_irq", 32'(irq), 32'h0);

    // Register access table
    foreach (vt[k]) begin
      do_req(vt[k].wr, vt[k].addr, vt[k].wdata, rd);
      chk("vec_rdata", 32'(rd), 32'(vt[k].exp));
      chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      if (vt[k].wr && vt[k].addr == 3'd0) chk("vec_dout", 32'(pad_dout), 32'(vt[k].wdata));
      if (vt[k].wr && vt[k].addr == 3'd1) chk("vec_oen",  32'(pad_oen),  32'(vt[k].wdata));
    end
    idle(1);

    // Backpressure: response held, request stalled, then 1 per cycle
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd0;
    tick();
    chk("bp_first", 32'(rsp_rdata), 32'h0A5);
    req_addr = 3'd1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      tick();
      chk("bp_hold_rdata", 32'(rsp_rdata), 32'h0A5);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(rsp_rdata), 32'h05A);
    req_addr = 3'd4;
    tick();
    chk("b2b_1", 32'(rsp_rdata), 32'h155);
    req_addr = 3'd0;
    tick();
    chk("b2b_2", 32'(rsp_rdata), 32'h0A5);
    req_valid = 1'b0;
    idle(1);

    // Rising edge on pad 0: status after 3 edges, irq one edge later
    do_req(1'b1, 3'd2, 9'h001, rd);
    do_req(1'b1, 3'd4, 9'h001, rd);
    do_req(1'b1, 3'd5, 9'h001, rd);
    idle(3);
    pad_din = 9'h001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("irq_latency_low", 32'(irq), 32'h0);
    end
    do_req(1'b0, 3'd6, '0, rd);
    chk("irq_status_set", 32'(rd), 32'h001);
    chk("irq_high", 32'(irq), 32'h1);
    do_req(1'b1, 3'd6, 9'h001, rd);
    chk("irq_w1c_edge", 32'(irq), 32'h1);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);
    pad_din = 9'h000;
    idle(5);
    do_req(1'b0, 3'd6, '0, rd);
    chk("falling_no_set", 32'(rd), 32'h000);

    // Enabling IE on a pad already at 1 must not look like an edge
    do_req(1'b1, 3'd5, 9'h009, rd);
    do_req(1'b1, 3'd4, 9'h009, rd);
    pad_din = 9'h008;
    idle(2);
    do_req(1'b1, 3'd2, 9'h008, rd);
    idle(4);
    do_req(1'b0, 3'd6, '0, rd);
    chk("ie_no_spurious", 32'(rd), 32'h000);
    do_req(1'b0, 3'd3, '0, rd);
    chk("din_sync", 32'(rd), 32'h008);
    chk("ie_irq_low", 32'(irq), 32'h0);

    // Edge event and w1c on the same bit in the same cycle: set wins
    do_req(1'b1, 3'd2, 9'h00A, rd);
    do_req(1'b1, 3'd5, 9'h00B, rd);
    do_req(1'b1, 3'd4, 9'h00B, rd);
    idle(4);
    pad_din = 9'h00A;
    idle(2);
    do_req(1'b1, 3'd6, 9'h002, rd);
    do_req(1'b0, 3'd6, '0, rd);
    chk("set_beats_clear", 32'(rd), 32'h002);
    chk("set_beats_clear_irq", 32'(irq), 32'h1);

    // Reset while a response is pending
    rsp_ready = 1'b0;
    do_req(1'b0, 3'd1, '0, rd);
    chk("pending_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_oen", 32'(pad_oen), 32'h1FF);
    chk("rst_dout", 32'(pad_dout), 32'h000);
    chk("rst_ie", 32'(pad_ie), 32'h000);
    chk("rst_irq", 32'(irq), 32'h0);
    do_req(1'b0, 3'd6, '0, rd);
    chk("rst_status", 32'(rd), 32'h000);
    do_req(1'b0, 3'd4, '0, rd);
    chk("rst_irq_en", 32'(rd), 32'h000);
    do_req(1'b0, 3'd5, '0, rd);
    chk("rst_irq_edge", 32'(rd), 32'h000);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = ($urandom_range(0, 1) == 1);
      req_addr  = 3'($urandom_range(0, 7));
      rnd       = $urandom;
      req_wdata = rnd[N-1:0];
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        rnd     = $urandom;
        pad_din = pad_din ^ rnd[N-1:0];
      end
      tick();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
